rolling_key_decryption: RTL and testbench

ROLLING_KEY_DECRYPTION -- requirements
Module: rolling_key_decryption

---
 rtl/rolling_key_decryption.sv | 195 +++++++++++++++++++
 tb/tb_rolling_key_decryption.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rolling_key_decryption.sv
`default_nettype none
// ============================================================================
// Module   : rolling_key_decryption
// Purpose  : Decrypts a stream of characters by subtracting a key chunk from
//            each character. Mode 0 always uses chunk 0 (fixed Caesar).
//            Mode 1 walks through the key chunks, one per character, starting
//            at chunk 0 for every message. Key and mode are captured with the
//            first character of a message. Decrypted characters are buffered
//            in a small output FIFO with a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1          rising-edge clock
//   rst         in   1          asynchronous active-high reset
//   data_i      in   D_WIDTH    encrypted character
//   valid_i     in   1          qualifies data_i / eom_i
//   eom_i       in   1          current character ends the message
//   mode_i      in   1          0 = fixed Caesar, 1 = rolling key
//   key         in   KEY_WIDTH  chunk i = key[i*D_WIDTH +: D_WIDTH]
//   busy        out  1          input not accepted this cycle
//   data_o      out  D_WIDTH    decrypted character at FIFO head
//   valid_o     out  1          FIFO not empty
//   ready_i     in   1          downstream accepts data_o
//   char_count  out  16         pushes in current message (saturating)
//                               -- present only with RKD_CHAR_COUNT_EN
// Configuration macro: RKD_CHAR_COUNT_EN (adds char_count output)
// ============================================================================
module rolling_key_decryption #(
  parameter int D_WIDTH    = 8,
  parameter int KEY_CHUNKS = 2,
  parameter int KEY_WIDTH  = 16,  // must equal KEY_CHUNKS*D_WIDTH
  parameter int FIFO_DEPTH = 4    // power of two, >= 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic                 eom_i,
  input  logic                 mode_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  input  logic                 ready_i
`ifdef RKD_CHAR_COUNT_EN
  ,
  output logic [15:0]          char_count
`endif
);

  localparam int IDX_W = (KEY_CHUNKS > 1) ? $clog2(KEY_CHUNKS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_CHUNKS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q;
  logic                 mode_q;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [D_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic                 push, pop, full, empty, first;
  logic [KEY_WIDTH-1:0] key_eff;
  logic                 mode_eff;
  logic [IDX_W-1:0]     idx_eff;
  logic [D_WIDTH-1:0]   chunk [KEY_CHUNKS];
  logic [D_WIDTH-1:0]   sub_key;
  logic [D_WIDTH-1:0]   plain;

  // --------------------------------------------------------------------------
  // Handshake and FIFO status
  // --------------------------------------------------------------------------
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign busy    = full | (state_q == S_DRAIN);
  assign push    = valid_i & ~busy;
  assign valid_o = ~empty;
  assign pop     = valid_o & ready_i;
  // Head is forced to zero when empty so data_o reads 0 out of reset.
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Key selection. The first character of a message is decrypted in the same
  // cycle its key/mode are latched, so in IDLE the live inputs are used and
  // the chunk index is forced to 0.
  // --------------------------------------------------------------------------
  assign first    = (state_q == S_IDLE);
  assign key_eff  = first ? key    : key_q;
  assign mode_eff = first ? mode_i : mode_q;
  assign idx_eff  = first ? '0     : idx_q;

  for (genvar g = 0; g < KEY_CHUNKS; g++) begin : g_chunk
    assign chunk[g] = key_eff[g*D_WIDTH +: D_WIDTH];
  end

  assign sub_key = mode_eff ? chunk[idx_eff] : chunk[0];
  assign plain   = data_i - sub_key;  // wraps modulo 2^D_WIDTH

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;

    unique case (state_q)
      S_IDLE:  if (push) state_d = eom_i ? S_DRAIN : S_RUN;
      S_RUN:   if (push && eom_i) state_d = S_DRAIN;
      S_DRAIN: if (empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      idx_d = (idx_eff == IDX_LAST) ? '0 : idx_eff + 1'b1;
    end else if (state_q == S_DRAIN && empty) begin
      idx_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (push && first) begin
        key_q  <= key;
        mode_q <= mode_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO pointers / occupancy. Pointers wrap naturally because the
  // depth is a power of two.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= plain;
  end

`ifdef RKD_CHAR_COUNT_EN
  // --------------------------------------------------------------------------
  // Per-message character counter, saturating at all-ones.
  // --------------------------------------------------------------------------
  logic [15:0] char_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_count_q <= '0;
    end else if (push) begin
      if (first)
        char_count_q <= 16'd1;
      else if (char_count_q != 16'hFFFF)
        char_count_q <= char_count_q + 16'd1;
    end
  end

  assign char_count = char_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rolling_key_decryption.sv
`default_nettype none
// ============================================================================
// Module   : tb_rolling_key_decryption
// Purpose  : Self-checking bench for rolling_key_decryption. A message-level
//            reference model predicts each decrypted character, whether the
//            DUT is busy, and FIFO occupancy; a monitor compares the FIFO head
//            against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rolling_key_decryption;

  localparam int DW    = 8;
  localparam int KC    = 2;
  localparam int KW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          eom_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [KW-1:0] key = '0;
  logic          busy;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
`ifdef RKD_CHAR_COUNT_EN
  logic [15:0]   char_count;
`endif

  rolling_key_decryption #(
    .D_WIDTH   (DW),
    .KEY_CHUNKS(KC),
    .KEY_WIDTH (KW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .eom_i     (eom_i),
    .mode_i    (mode_i),
    .key       (key),
    .busy      (busy),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
`ifdef RKD_CHAR_COUNT_EN
    ,
    .char_count(char_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  int            occ_m    = 0;
  bit            drain_m  = 1'b0;
  bit            push_now = 1'b0;
  bit            eom_now  = 1'b0;
  bit            pop_now  = 1'b0;
  bit            in_msg   = 1'b0;
  logic [KW-1:0] key_m    = '0;
  bit            mode_m   = 1'b0;
  int            k_m      = 0;
  int            cnt_m    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy / drain model, advanced on each clock edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_m   = 0;
      drain_m = 1'b0;
    end else begin
      if (drain_m) begin
        if (occ_m == 0) drain_m = 1'b0;
      end else if (push_now && eom_now) begin
        drain_m = 1'b1;
      end
      occ_m = occ_m + (push_now ? 1 : 0) - (pop_now ? 1 : 0);
    end
  end

  // Monitor: compares FIFO head with scoreboard, pops on handshake
  always @(negedge clk) begin
    pop_now = 1'b0;
    if (!rst) begin
      chk("valid_o", valid_o, occ_m != 0);
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", valid_o, 1'b0);
        end else begin
          chk("data_o", data_o, exp_q[0]);
          if (ready_i) begin
            void'(exp_q.pop_front());
            pop_now = 1'b1;
          end
        end
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1
  task automatic step(input bit v, input logic [DW-1:0] d, input bit e);
    bit            exp_busy;
    logic [DW-1:0] ch;
    exp_busy = (occ_m == DEPTH) || drain_m;
    valid_i  = v;
    data_i   = d;
    eom_i    = e;
    chk("busy", busy, exp_busy);
    push_now = v && !exp_busy;
    eom_now  = e;
    if (push_now) begin
      if (!in_msg) begin
        key_m  = key;
        mode_m = mode_i;
        k_m    = 0;
        cnt_m  = 0;
      end
      ch = mode_m ? key_m[k_m*DW +: DW] : key_m[DW-1:0];
      exp_q.push_back(d - ch);
      k_m    = (k_m + 1) % KC;
      cnt_m  = (cnt_m == 16'hFFFF) ? cnt_m : cnt_m + 1;
      in_msg = !e;
    end
    @(posedge clk);
    #1;
`ifdef RKD_CHAR_COUNT_EN
    if (push_now) chk("char_count", char_count, cnt_m);
`endif
    push_now = 1'b0;
    valid_i  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    ready_i = 1'b1;
    while ((occ_m != 0 || drain_m) && n < 200) begin
      step(1'b0, '0, 1'b0);
      n++;
    end
    chk("drain_done", (occ_m == 0 && !drain_m), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data_o", data_o, 8'h00);
`ifdef RKD_CHAR_COUNT_EN
    chk("rst_char_count", char_count, 16'h0000);
`endif
    rst = 1'b0;

    // Rolling key, 3-character message
    mode_i = 1'b1; key = 16'h0302; ready_i = 1'b1;
    step(1'b1, 8'h61, 1'b0);
    step(1'b1, 8'h62, 1'b0);
    step(1'b1, 8'h63, 1'b1);
    wait_drain();

    // Fixed Caesar with wrap-around
    mode_i = 1'b0;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h61, 1'b1);
    wait_drain();

    // Fill FIFO with output stalled; fifth character must be dropped
    mode_i = 1'b1; ready_i = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
    wait_drain();
    step(1'b1, 8'h70, 1'b1);
    wait_drain();

    // Key change mid-message is ignored until the next message
    key = 16'h0302;
    step(1'b1, 8'h10, 1'b0);
    key = 16'h0505;
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h30, 1'b1);
    wait_drain();
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h50, 1'b1);
    wait_drain();

    // Asynchronous reset with two entries buffered
    key = 16'h0302; ready_i = 1'b0;
    step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    in_msg = 1'b0; push_now = 1'b0; pop_now = 1'b0;
    #1;
    chk("async_rst_valid_o", valid_o, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0; ready_i = 1'b1;
    step(1'b1, 8'h61, 1'b0);
    step(1'b1, 8'h62, 1'b1);
    wait_drain();

    // Randomized messages with random gaps, back-pressure and key changes
    for (int m = 0; m < 40; m++) begin
      int len;
      len    = $urandom_range(1, 5);
      mode_i = 1'($urandom_range(0, 1));
      key    = 16'($urandom);
      for (int c = 0; c < len; c++) begin
        while ($urandom_range(0, 3) == 0) begin
          ready_i = ($urandom_range(0, 3) != 0);
          step(1'b0, 8'($urandom), 1'($urandom));
        end
        ready_i = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 4) == 0) key = 16'($urandom);
        if ($urandom_range(0, 6) == 0) mode_i = ~mode_i;
        step(1'b1, 8'($urandom), c == len - 1);
      end
      if ($urandom_range(0, 1) == 1) wait_drain();
    end
    wait_drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
